usb_cmd_parser: RTL and testbench

- Downstream consumer of the USB receive FIFO.
- Pops 32-bit words via the FIFO's rdreq/rdempty handshake.
- Assembles 3-word command frames, validates sync, opcode, channel and checksum.
- Presents decoded DC-channel set-points and global load strobes to the DAC update logic.

---
 rtl/usb_cmd_parser.sv | 215 +++++++++++++++++++++
 tb/tb_usb_cmd_parser.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cmd_parser.sv
// usb_cmd_parser
//   Pops 32-bit words from the USB receive FIFO, assembles 3-word command
//   frames (header, data, checksum), validates them and presents DC-channel
//   set-points and global load strobes to the DAC update logic.
//
//   Frame: W0 = {8'hA5 sync, opcode, channel, seq}, W1 = data, W2 = W0 ^ W1.
//   Opcode 0x01 -> set-point on cmd_* (valid/ready), 0x02 -> load_all pulse.
//
// Optional feature (macro SEQ_CHECK_EN): sequence-number tracking. When the
//   macro is defined, a checksum-good frame whose seq differs from the
//   expected value is rejected and expected is resynchronised to seq+1.
//
// Ports:
//   clkfpga    system clock, rising edge
//   rst        asynchronous active-high reset
//   rdempty    FIFO empty flag (registered, one cycle stale)
//   out32      FIFO read data
//   rdreq      single-cycle pop request
//   cmd_valid  set-point valid, held until cmd_ready
//   cmd_ready  consumer accepts set-point
//   cmd_chan   set-point channel index
//   cmd_data   set-point value
//   load_all   one-cycle strobe: latch all DAC channels
//   frame_cnt  good frames (wraps)
//   err_cnt    rejected frames (saturates at 0xFF)
module usb_cmd_parser #(
    parameter int NCHAN   = 8,
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic        clkfpga,
    input  logic        rst,
    input  logic        rdempty,
    input  logic [31:0] out32,
    output logic        rdreq,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_chan,
    output logic [31:0] cmd_data,
    output logic        load_all,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam int LW = $clog2(RD_LAT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_SETTLE} rd_state_t;
    typedef enum logic [1:0] {HUNT, DATA, CSUM, EMIT} state_t;

    rd_state_t       rd_st;
    logic [LW-1:0]   lat_cnt;
    logic            word_vld;
    logic [31:0]     word;

    state_t          state, state_n;
    logic [31:0]     hdr, dat;
    logic [TW-1:0]   tmo_cnt;

    logic            hdr_we, dat_we, err_inc, frm_inc, load_n;
    logic            csum_ok, chan_ok, tmo_hit, seq_bad;
    logic [7:0]      opc;

    // ------------------------------------------------------------------
    // Read engine: at most one read outstanding. The settle cycle after
    // each capture gives the stale rdempty flag time to catch up with the
    // pop, so we never request from an empty FIFO.
    // ------------------------------------------------------------------
    always_ff @(posedge clkfpga or posedge rst) begin
        if (rst) begin
            rd_st    <= RD_IDLE;
            rdreq    <= 1'b0;
            lat_cnt  <= '0;
            word_vld <= 1'b0;
            word     <= '0;
        end else begin
            rdreq    <= 1'b0;
            word_vld <= 1'b0;
            case (rd_st)
                RD_IDLE: begin
                    // EMIT holds off reads: backpressure into the FIFO
                    if (!rdempty && state != EMIT) begin
                        rdreq   <= 1'b1;
                        lat_cnt <= LW'(RD_LAT - 1);
                        rd_st   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        word     <= out32;
                        word_vld <= 1'b1;
                        rd_st    <= RD_SETTLE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RD_SETTLE: rd_st <= RD_IDLE;
                default:   rd_st <= RD_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame decode
    // ------------------------------------------------------------------
    assign opc     = hdr[23:16];
    assign csum_ok = (word == (hdr ^ dat));
    assign chan_ok = ({24'd0, hdr[15:8]} < NCHAN);
    // The timeout only advances while no read is in flight, so a word that
    // is already on its way is always consumed by the state that asked for it.
    assign tmo_hit = !word_vld && rd_st == RD_IDLE && tmo_cnt == TW'(TIMEOUT - 1);

`ifdef SEQ_CHECK_EN
    logic       seq_vld, seq_upd;
    logic [7:0] seq_exp;

    assign seq_bad = seq_vld && (hdr[7:0] != seq_exp);
    // Resync on a seq mismatch as well as on every accepted frame.
    assign seq_upd = (state == CSUM) && word_vld && csum_ok &&
                     (seq_bad || (opc == 8'h01 && chan_ok) || opc == 8'h02);

    always_ff @(posedge clkfpga or posedge rst) begin
        if (rst) begin
            seq_vld <= 1'b0;
            seq_exp <= '0;
        end else if (seq_upd) begin
            seq_vld <= 1'b1;
            seq_exp <= hdr[7:0] + 8'd1;
        end
    end
`else
    assign seq_bad = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        hdr_we    = 1'b0;
        dat_we    = 1'b0;
        err_inc   = 1'b0;
        frm_inc   = 1'b0;
        load_n    = 1'b0;
        cmd_valid = 1'b0;
        case (state)
            HUNT: begin
                // non-sync words are silently dropped
                if (word_vld && word[31:24] == 8'hA5) begin
                    hdr_we  = 1'b1;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (word_vld) begin
                    dat_we  = 1'b1;
                    state_n = CSUM;
                end else if (tmo_hit) begin
                    err_inc = 1'b1;
                    state_n = HUNT;
                end
            end
            CSUM: begin
                if (word_vld) begin
                    state_n = HUNT;
                    if (!csum_ok || seq_bad) begin
                        err_inc = 1'b1;
                    end else if (opc == 8'h01 && chan_ok) begin
                        state_n = EMIT;
                    end else if (opc == 8'h02) begin
                        load_n  = 1'b1;
                        frm_inc = 1'b1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end else if (tmo_hit) begin
                    err_inc = 1'b1;
                    state_n = HUNT;
                end
            end
            EMIT: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    frm_inc = 1'b1;
                    state_n = HUNT;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    assign cmd_chan = hdr[15:8];
    assign cmd_data = dat;

    always_ff @(posedge clkfpga or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            hdr       <= '0;
            dat       <= '0;
            tmo_cnt   <= '0;
            load_all  <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            state    <= state_n;
            load_all <= load_n;
            if (hdr_we) hdr <= word;
            if (dat_we) dat <= word;
            if (word_vld || !(state == DATA || state == CSUM))
                tmo_cnt <= '0;
            else if (rd_st == RD_IDLE)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (frm_inc) frame_cnt <= frame_cnt + 16'd1;
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Self-checking bench for usb_cmd_parser: a FIFO model feeds frames, a
// frame-level reference model predicts set-points, load strobes and counters,
// and a negedge monitor compares the DUT against the scoreboard queue.
module tb_usb_cmd_parser;

    localparam int NCHAN   = 8;
    localparam int TIMEOUT = 1024;

    logic        clkfpga = 1'b0;
    logic        rst     = 1'b1;
    logic        rdempty = 1'b1;
    logic [31:0] out32   = '0;
    logic        rdreq;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_chan;
    logic [31:0] cmd_data;
    logic        load_all;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    always #5 clkfpga = ~clkfpga;

    usb_cmd_parser #(.NCHAN(NCHAN), .RD_LAT(2), .TIMEOUT(TIMEOUT)) dut (
        .clkfpga  (clkfpga),
        .rst      (rst),
        .rdempty  (rdempty),
        .out32    (out32),
        .rdreq    (rdreq),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_chan (cmd_chan),
        .cmd_data (cmd_data),
        .load_all (load_all),
        .frame_cnt(frame_cnt),
        .err_cnt  (err_cnt)
    );

    typedef struct packed {
        logic        is_load;
        logic [7:0]  chan;
        logic [31:0] data;
    } ev_t;

    logic [31:0] fifo[$];
    ev_t         exp_q[$];
    int          n_cmp = 0, n_bad = 0;
    int          exp_frames = 0, exp_errs = 0;
    bit          m_seq_vld = 0;
    logic [7:0]  m_seq_exp = '0;
    logic [7:0]  tb_seq = '0;
    int          rdy_mode = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FIFO with one-cycle-stale registered empty flag and registered read data
    always @(posedge clkfpga) begin
        rdempty <= (fifo.size() == 0);
        if (rdreq) begin
            n_cmp++;
            if (fifo.size() != 0) begin
                out32 <= fifo.pop_front();
            end else begin
                n_bad++;
                $display("FAIL fifo_pop: got rdreq on empty fifo, expected no pop");
            end
        end
    end

    // consumer ready: 0 = always ready, 1 = random, 2 = stalled
    always @(posedge clkfpga) begin
        #2;
        case (rdy_mode)
            0:       cmd_ready = 1'b1;
            1:       cmd_ready = 1'($urandom_range(1, 0));
            default: cmd_ready = 1'b0;
        endcase
    end

    // Monitor
    bit          hold_prev = 0;
    logic [7:0]  prev_chan;
    logic [31:0] prev_data;
    always @(negedge clkfpga) begin
        if (!rst) begin
            ev_t e;
            if (hold_prev)
                chk("hold_stable", 64'({cmd_valid, cmd_chan, cmd_data}),
                    64'({1'b1, prev_chan, prev_data}));
            if (cmd_valid)
                chk("no_rdreq_in_emit", 64'(rdreq), 64'(0));
            if (cmd_valid && cmd_ready) begin
                chk("cmd_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("cmd", 64'({1'b0, cmd_chan, cmd_data}), 64'(e));
                end
            end
            if (load_all) begin
                chk("load_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("load_all", 64'(e.is_load), 64'(1));
                end
            end
            hold_prev = cmd_valid && !cmd_ready;
            prev_chan = cmd_chan;
            prev_data = cmd_data;
        end
    end

    // Frame-level reference model
    task automatic model_frame(input logic [7:0] opc, input logic [7:0] chan,
                               input logic [7:0] seq, input logic [31:0] data, input bit bad);
        ev_t e;
        bit  seq_rej;
        seq_rej = 1'b0;
`ifdef SEQ_CHECK_EN
        seq_rej = m_seq_vld && (seq != m_seq_exp);
`endif
        if (bad) begin
            exp_errs++;
        end else if (seq_rej) begin
            exp_errs++;
            m_seq_exp = seq + 8'd1;
        end else if (opc == 8'h01 && chan < NCHAN) begin
            e.is_load = 1'b0; e.chan = chan; e.data = data;
            exp_q.push_back(e);
            exp_frames++;
            m_seq_vld = 1; m_seq_exp = seq + 8'd1;
        end else if (opc == 8'h02) begin
            e.is_load = 1'b1; e.chan = '0; e.data = '0;
            exp_q.push_back(e);
            exp_frames++;
            m_seq_vld = 1; m_seq_exp = seq + 8'd1;
        end else begin
            exp_errs++;
        end
    endtask

    task automatic send_frame_seq(input logic [7:0] opc, input logic [7:0] chan,
                                  input logic [7:0] seq, input logic [31:0] data, input bit bad);
        logic [31:0] w0, w2;
        @(negedge clkfpga);
        w0 = {8'hA5, opc, chan, seq};
        w2 = w0 ^ data;
        if (bad) w2 = w2 ^ (32'h1 << $urandom_range(31, 0));
        fifo.push_back(w0);
        fifo.push_back(data);
        fifo.push_back(w2);
        model_frame(opc, chan, seq, data, bad);
    endtask

    task automatic send_frame(input logic [7:0] opc, input logic [7:0] chan,
                              input logic [31:0] data, input bit bad);
        send_frame_seq(opc, chan, tb_seq, data, bad);
        tb_seq = tb_seq + 8'd1;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0) && c < budget) begin
            @(negedge clkfpga);
            c++;
        end
        repeat (20) @(negedge clkfpga);
        chk("drain_in_time", 64'(c < budget), 64'(1));
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames[15:0]));
        chk("err_cnt", 64'(err_cnt), 64'((exp_errs > 255) ? 255 : exp_errs));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  opc, chan, seq;
        logic [31:0] w0;
        int          c, r, err_before;

        // Reset state
        repeat (3) @(posedge clkfpga);
        @(negedge clkfpga);
        chk("reset_outputs",
            64'({rdreq, cmd_valid, load_all, frame_cnt, err_cnt, cmd_chan}), 64'(0));
        chk("reset_cmd_data", 64'(cmd_data), 64'(0));
        rst = 1'b0;
        rdy_mode = 0;

        // Directed frames
        send_frame(8'h01, 8'h03, 32'h0000_1234, 0);
        drain(500);
        send_frame(8'h02, 8'h00, 32'h0000_0000, 0);
        drain(500);
        @(negedge clkfpga);
        fifo.push_back(32'hFFFF_FFFF);
        fifo.push_back(32'h1234_5678);
        send_frame(8'h01, 8'h07, 32'hDEAD_BEEF, 0);
        drain(500);
        send_frame(8'h01, 8'h01, 32'h5555_AAAA, 1);
        send_frame(8'h01, 8'h02, 32'h0BAD_F00D, 0);
        drain(500);
        send_frame(8'h01, 8'h08, 32'h1111_2222, 0);
        send_frame(8'h07, 8'h00, 32'h3333_4444, 0);
        drain(500);

        // Backpressure: hold ready low with a second frame queued
        rdy_mode = 2;
        send_frame(8'h01, 8'h05, 32'hCAFE_0005, 0);
        send_frame(8'h01, 8'h02, 32'hCAFE_0002, 0);
        c = 0;
        while (!cmd_valid && c < 200) begin
            @(negedge clkfpga);
            c++;
        end
        chk("emit_reached", 64'(c < 200), 64'(1));
        repeat (50) @(negedge clkfpga);
        chk("fifo_held", 64'(fifo.size()), 64'(3));
        rdy_mode = 0;
        drain(500);

        // Randomized traffic
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            r    = int'($urandom_range(9, 0));
            seq  = ($urandom_range(7, 0) == 0) ? 8'($urandom) : tb_seq;
            chan = 8'($urandom_range(NCHAN - 1, 0));
            case (r)
                0: begin
                    @(negedge clkfpga);
                    fifo.push_back({8'($urandom_range(164, 0)), 24'($urandom)});
                end
                1: send_frame_seq(8'h01, chan, seq, $urandom, 1);
                2: send_frame_seq(8'h02, chan, seq, $urandom, 0);
                3: begin
                    opc = 8'($urandom);
                    if (opc == 8'h01 || opc == 8'h02) opc = 8'h03;
                    send_frame_seq(opc, chan, seq, $urandom, 0);
                end
                4: send_frame_seq(8'h01, 8'($urandom_range(255, NCHAN)), seq, $urandom, 0);
                default: send_frame_seq(8'h01, chan, seq, $urandom, 0);
            endcase
            tb_seq = seq + 8'd1;
            repeat ($urandom_range(10, 0)) @(negedge clkfpga);
        end
        drain(20000);
        rdy_mode = 0;

        // Timeout: header only, then silence
        @(negedge clkfpga);
        fifo.push_back({8'hA5, 8'h01, 8'h03, tb_seq});
        exp_errs++;
        repeat (1100) @(negedge clkfpga);
        chk("timeout_err", 64'(err_cnt), 64'((exp_errs > 255) ? 255 : exp_errs));
        send_frame(8'h01, 8'h04, 32'h7777_0004, 0);
        drain(500);

        // Long gap just under the timeout still completes the frame
        @(negedge clkfpga);
        w0 = {8'hA5, 8'h01, 8'h06, tb_seq};
        fifo.push_back(w0);
        repeat (1000) @(negedge clkfpga);
        fifo.push_back(32'h0600_0006);
        fifo.push_back(w0 ^ 32'h0600_0006);
        model_frame(8'h01, 8'h06, tb_seq, 32'h0600_0006, 0);
        tb_seq = tb_seq + 8'd1;
        drain(500);

`ifdef SEQ_CHECK_EN
        send_frame_seq(8'h01, 8'h01, 8'd4, 32'h0000_0004, 0);
        drain(500);
        err_before = int'(err_cnt);
        send_frame_seq(8'h01, 8'h01, 8'd5, 32'h0000_0005, 0);
        send_frame_seq(8'h01, 8'h01, 8'd7, 32'h0000_0007, 0);
        drain(500);
        chk("seq_gap_rejected", 64'(int'(err_cnt) - err_before), 64'(1));
`else
        err_before = int'(err_cnt);
        send_frame_seq(8'h01, 8'h01, 8'd5, 32'h0000_0005, 0);
        send_frame_seq(8'h01, 8'h01, 8'd7, 32'h0000_0007, 0);
        drain(500);
        chk("seq_ignored", 64'(int'(err_cnt) - err_before), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
